// File: rtl/sm_ram_arbiter.sv
// sm_ram_arbiter: shares the schoolMIPS single-port data RAM between the CPU (m0) and a debug port (m1).
// Define SM_RAM_ARB_RR_EN for round-robin arbitration instead of CPU priority with m1 anti-starvation.
module sm_ram_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_req_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_addr_i,
    input  logic [DATA_WIDTH-1:0] m0_wdata_i,
    output logic                  m0_gnt_o,
    output logic                  m0_rvalid_o,
    output logic [DATA_WIDTH-1:0] m0_rdata_o,
    input  logic                  m1_req_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_addr_i,
    input  logic [DATA_WIDTH-1:0] m1_wdata_i,
    output logic                  m1_gnt_o,
    output logic                  m1_rvalid_o,
    output logic [DATA_WIDTH-1:0] m1_rdata_o,
    output logic                  ram_en_o,
    output logic                  ram_we_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    input  logic [DATA_WIDTH-1:0] ram_rdata_i,
    output logic [2:0]            wait_cnt_o
);
    logic       m1_first;
    logic [2:0] wait_cnt_q, wait_cnt_d;
    logic       m0_rd_q, m1_rd_q;

`ifdef SM_RAM_ARB_RR_EN
    logic last_m1_q, last_m1_d;
    assign m1_first   = !last_m1_q;
    assign last_m1_d  = m1_gnt_o ? 1'b1 : m0_gnt_o ? 1'b0 : last_m1_q;
    assign wait_cnt_d = '0;
    always_ff @(posedge clk) begin
        if (rst) last_m1_q <= 1'b1;
        else     last_m1_q <= last_m1_d;
    end
`else
    localparam logic [2:0] MW = 3'(MAX_WAIT);
    assign m1_first   = (MAX_WAIT != 0) && (wait_cnt_q == MW);
    assign wait_cnt_d = (m1_gnt_o || !m1_req_i) ? 3'd0 :
                        (wait_cnt_q == MW)      ? wait_cnt_q : wait_cnt_q + 3'd1;
`endif

    // m1_first decides contention only; a lone requester always wins
    assign m0_gnt_o = !rst && m0_req_i && !(m1_req_i && m1_first);
    assign m1_gnt_o = !rst && m1_req_i && !(m0_req_i && !m1_first);
    assign ram_en_o = m0_gnt_o | m1_gnt_o;

    always_comb begin
        ram_we_o    = m0_gnt_o ? m0_we_i    : m1_gnt_o ? m1_we_i    : 1'b0;
        ram_addr_o  = m0_gnt_o ? m0_addr_i  : m1_gnt_o ? m1_addr_i  : '0;
        ram_wdata_o = m0_gnt_o ? m0_wdata_i : m1_gnt_o ? m1_wdata_i : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt_q <= '0;
            m0_rd_q    <= 1'b0;
            m1_rd_q    <= 1'b0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
            m0_rd_q    <= m0_gnt_o && !m0_we_i;
            m1_rd_q    <= m1_gnt_o && !m1_we_i;
        end
    end

    // a reset arriving the cycle after a read grant drops that read
    assign m0_rvalid_o = m0_rd_q && !rst;
    assign m1_rvalid_o = m1_rd_q && !rst;
    assign m0_rdata_o  = ram_rdata_i;
    assign m1_rdata_o  = ram_rdata_i;
    assign wait_cnt_o  = wait_cnt_q;
endmodule

// File: tb/tb_sm_ram_arbiter.sv
// tb_sm_ram_arbiter: vector table with expected grants, plus a read-return scoreboard fed by a shadow RAM.
module tb_sm_ram_arbiter;
    typedef struct {
        logic rst, r0, w0; logic [5:0] a0; logic [31:0] d0;
        logic r1, w1; logic [5:0] a1; logic [31:0] d1;
        logic g0, g1; logic [2:0] wc;
    } vec_t;
    typedef struct { logic v0, v1; logic [31:0] d; } sb_t;

`ifdef SM_RAM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0, rst = 1'b1;
    logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [5:0] m0_addr = 0, m1_addr = 0;
    logic [31:0] m0_wdata = 0, m1_wdata = 0;
    logic m0_gnt, m0_rvalid, m1_gnt, m1_rvalid, ram_en, ram_we;
    logic [31:0] m0_rdata, m1_rdata, ram_wdata, ram_rdata;
    logic [5:0] ram_addr;
    logic [2:0] wait_cnt;
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    vec_t vecs[$];
    sb_t sb_q[$];
    int tests = 0, fails = 0, row = 0;

    sm_ram_arbiter dut (
        .clk(clk), .rst(rst),
        .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
        .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_rdata_o(m0_rdata),
        .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
        .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_rdata_o(m1_rdata),
        .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
        .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata), .wait_cnt_o(wait_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        ram_rdata <= mem[ram_addr];
        end
    end

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s row %0d: got %h, expected %h", n, row, act, exp);
        end
    endtask

    task automatic add(input logic rs, input logic r0, input logic w0, input logic [5:0] a0,
                       input logic [31:0] d0, input logic r1, input logic w1, input logic [5:0] a1,
                       input logic [31:0] d1, input logic g0, input logic g1, input logic [2:0] wc);
        vec_t v;
        v = '{rs, r0, w0, a0, d0, r1, w1, a1, d1, g0, g1, wc};
        vecs.push_back(v);
    endtask

    function automatic logic [2:0] fw(input int n);
        return RR ? 3'd0 : 3'(n);
    endfunction

    initial begin
        sb_t e, p;
        vec_t v;
        for (int i = 0; i < 64; i++) begin
            mem[i] = 32'hA500_0000 | i;
            ref_mem[i] = 32'hA500_0000 | i;
        end
        mem[5] = 32'h0000_1234;
        ref_mem[5] = 32'h0000_1234;
        //  rst r0 w0 a0  d0             r1 w1 a1  d1             g0     g1     wc
        add(0,  0, 0, 0,  0,             0, 0, 0,  0,             0,     0,     0);
        add(1,  1, 0, 7,  0,             0, 0, 0,  0,             0,     0,     0);
        add(0,  1, 0, 5,  0,             0, 0, 0,  0,             1,     0,     0);
        add(0,  0, 0, 0,  0,             0, 0, 0,  0,             0,     0,     0);
        add(0,  0, 0, 0,  0,             1, 1, 3,  32'hDEADBEEF,  0,     1,     0);
        add(0,  1, 0, 3,  0,             0, 0, 0,  0,             1,     0,     0);
        add(0,  0, 0, 0,  0,             0, 0, 0,  0,             0,     0,     0);
        add(0,  0, 0, 0,  0,             1, 0, 3,  0,             0,     1,     0);
        add(0,  1, 0, 10, 0,             1, 0, 11, 0,             1,     0,     fw(0));
        add(0,  1, 0, 10, 0,             1, 0, 11, 0,             !RR,   RR,    fw(1));
        add(0,  1, 0, 10, 0,             1, 0, 11, 0,             1,     0,     fw(2));
        add(0,  1, 0, 10, 0,             1, 0, 11, 0,             !RR,   RR,    fw(3));
        add(0,  1, 0, 10, 0,             1, 0, 11, 0,             RR,    !RR,   fw(4));
        add(0,  1, 0, 10, 0,             1, 0, 11, 0,             !RR,   RR,    fw(0));
        add(0,  0, 0, 0,  0,             1, 0, 11, 0,             0,     1,     fw(RR ? 0 : 1));
        add(0,  0, 0, 0,  0,             0, 0, 0,  0,             0,     0,     0);
        add(0,  1, 0, 12, 0,             1, 0, 13, 0,             1,     0,     0);
        add(0,  1, 1, 12, 32'h5555AAAA,  0, 0, 0,  0,             1,     0,     fw(1));
        add(0,  0, 0, 0,  0,             0, 0, 0,  0,             0,     0,     0);
        add(0,  1, 0, 2,  0,             0, 0, 0,  0,             1,     0,     0);
        add(1,  0, 0, 0,  0,             0, 0, 0,  0,             0,     0,     0);
        add(0,  0, 0, 0,  0,             0, 0, 0,  0,             0,     0,     0);
        add(0,  0, 0, 0,  0,             1, 0, 20, 0,             0,     1,     0);
        add(0,  0, 0, 0,  0,             1, 0, 21, 0,             0,     1,     0);
        add(0,  0, 0, 12, 0,             1, 0, 12, 0,             0,     1,     0);
        add(0,  0, 0, 0,  0,             0, 0, 0,  0,             0,     0,     0);

        repeat (2) @(posedge clk);
        p = '{1'b0, 1'b0, 32'h0};
        sb_q.push_back(p);
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            row = i;
            @(negedge clk);
            rst = v.rst;
            m0_req = v.r0; m0_we = v.w0; m0_addr = v.a0; m0_wdata = v.d0;
            m1_req = v.r1; m1_we = v.w1; m1_addr = v.a1; m1_wdata = v.d1;
            #1;
            chk("m0_gnt", 32'(m0_gnt), 32'(v.g0));
            chk("m1_gnt", 32'(m1_gnt), 32'(v.g1));
            chk("ram_en", 32'(ram_en), 32'(v.g0 | v.g1));
            chk("wait_cnt", 32'(wait_cnt), 32'(v.wc));
            if (v.g0 | v.g1) begin
                chk("ram_addr", 32'(ram_addr), 32'(v.g0 ? v.a0 : v.a1));
                chk("ram_we", 32'(ram_we), 32'(v.g0 ? v.w0 : v.w1));
            end
            e = sb_q.pop_front();
            chk("m0_rvalid", 32'(m0_rvalid), 32'(e.v0 && !v.rst));
            chk("m1_rvalid", 32'(m1_rvalid), 32'(e.v1 && !v.rst));
            if (e.v0 && !v.rst) chk("m0_rdata", m0_rdata, e.d);
            if (e.v1 && !v.rst) chk("m1_rdata", m1_rdata, e.d);
            p.v0 = v.g0 && !v.w0;
            p.v1 = v.g1 && !v.w1;
            p.d  = ref_mem[v.g0 ? v.a0 : v.a1];
            if (v.g0 && v.w0) ref_mem[v.a0] = v.d0;
            if (v.g1 && v.w1) ref_mem[v.a1] = v.d1;
            sb_q.push_back(p);
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
